// File: rtl/gcd_sched.sv
// Two-requester GCD engine: round-robin capture of an operand pair, then one
// subtract-and-compare step per clock until the pair converges.
module gcd_sched #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic [1:0]   ack,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic [N-1:0] gcd,
    output logic         zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic [N-1:0] a_reg, a_next;
    logic [N-1:0] b_reg, b_next;
    logic [N-1:0] gcd_reg, gcd_next;
    logic         id_reg, id_next;
    logic         last_reg, last_next;
    logic         done_reg, done_next;
    logic         done_id_reg, done_id_next;
    logic         zero_reg, zero_next;
    logic [1:0]   ack_reg, ack_next;

    logic         capture;
    logic         grant;
    logic         a_is_zero;
    logic         b_is_zero;
    logic         a_gt_b;

    // On contention the requester that did not win last time is served.
    assign capture = (state_reg == IDLE) && (req != 2'b00);
    assign grant   = (req == 2'b11) ? ~last_reg : req[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_next[gi] = capture && (grant == 1'(gi));
        end
    endgenerate

    assign a_is_zero = (a_reg == '0);
    assign b_is_zero = (b_reg == '0);
    assign a_gt_b    = (a_reg > b_reg);

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        gcd_next     = gcd_reg;
        id_next      = id_reg;
        last_next    = last_reg;
        done_next    = 1'b0;
        done_id_next = done_id_reg;
        zero_next    = zero_reg;

        case (state_reg)
            IDLE: begin
                if (capture) begin
                    a_next     = grant ? a1 : a0;
                    b_next     = grant ? b1 : b0;
                    id_next    = grant;
                    last_next  = grant;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (a_is_zero || b_is_zero) begin
                    gcd_next     = a_reg | b_reg;
                    zero_next    = a_is_zero && b_is_zero;
                    done_next    = 1'b1;
                    done_id_next = id_reg;
                    state_next   = DONE;
                end else if (a_reg == b_reg) begin
                    gcd_next     = a_reg;
                    zero_next    = 1'b0;
                    done_next    = 1'b1;
                    done_id_next = id_reg;
                    state_next   = DONE;
                end else if (a_gt_b) begin
                    a_next = a_reg - b_reg;
                end else begin
                    b_next = b_reg - a_reg;
                end
            end
            DONE: begin
                // No capture here even with req high; IDLE is re-entered first.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            gcd_reg     <= '0;
            id_reg      <= 1'b0;
            last_reg    <= 1'b1;
            done_reg    <= 1'b0;
            done_id_reg <= 1'b0;
            zero_reg    <= 1'b0;
            ack_reg     <= 2'b00;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            gcd_reg     <= gcd_next;
            id_reg      <= id_next;
            last_reg    <= last_next;
            done_reg    <= done_next;
            done_id_reg <= done_id_next;
            zero_reg    <= zero_next;
            ack_reg     <= ack_next;
        end
    end

    assign ack     = ack_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign done_id = done_id_reg;
    assign gcd     = gcd_reg;
    assign zero    = zero_reg;

endmodule

// File: tb/tb_gcd_sched.sv
// Randomized scoreboard bench for gcd_sched: the driver predicts grants and
// results with a Euclid-based model, the monitor checks every ack/done pulse.
module tb_gcd_sched;

    typedef struct {
        logic       id;
        logic [7:0] g;
        logic       z;
        int         k;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0] ack;
    logic       busy, done, done_id, zero;
    logic [7:0] gcd;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic gq[$];
    exp_t rq[$];

    logic [1:0] pend = 2'b00;
    logic       m_last = 1'b1;

    gcd_sched #(.N(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack(ack), .busy(busy), .done(done), .done_id(done_id),
        .gcd(gcd), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: gcd via remainders; subtraction count is the sum of Euclid
    // quotients minus the final step that would reach equality.
    function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int x, y, q, r, k;
        e.id = id;
        if (a == 0 || b == 0) begin
            e.g = a | b;
            e.z = (a == 0) && (b == 0);
            e.k = 0;
        end else begin
            x = int'(a);
            y = int'(b);
            k = 0;
            while (y != 0) begin
                q = x / y;
                r = x % y;
                k += q;
                x = y;
                y = r;
            end
            e.g = 8'(x);
            e.z = 1'b0;
            e.k = k - 1;
        end
        return e;
    endfunction

    function automatic logic [7:0] rand_op();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom_range(1, 120));
    endfunction

    // Monitor: pops expectations on every ack and done pulse.
    int   ack_cyc = 0;
    bit   job_active = 0;
    int   busy_low = 0;
    int   gcd_changes = 0;
    logic [7:0] last_gcd = '0;
    logic eg;
    exp_t er;

    always @(negedge clk) begin
        if (rst) begin
            job_active  = 0;
            gcd_changes = 0;
            last_gcd    = '0;
        end else begin
            if (ack != 2'b00) begin
                if (gq.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 0);
                end else begin
                    eg = gq.pop_front();
                    check("ack_grant", 32'(ack), eg ? 32'd2 : 32'd1);
                    ack_cyc    = cyc;
                    job_active = 1;
                    busy_low   = 0;
                end
            end
            if (job_active && !busy) busy_low++;
            if (done) begin
                if (rq.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    er = rq.pop_front();
                    check("done_id", 32'(done_id), 32'(er.id));
                    check("gcd", 32'(gcd), 32'(er.g));
                    check("zero", 32'(zero), 32'(er.z));
                    check("latency", 32'(cyc - ack_cyc), 32'(er.k + 1));
                    check("busy_in_job", 32'(busy_low), 0);
                    check("gcd_hold", 32'(gcd_changes), 0);
                    $display("job id=%0d gcd=%0d zero=%0d subs=%0d cycles_from_ack=%0d",
                             done_id, gcd, zero, er.k, cyc - ack_cyc);
                end
                job_active  = 0;
                gcd_changes = 0;
                last_gcd    = gcd;
            end else if (gcd != last_gcd) begin
                gcd_changes++;
            end
        end
    end

    task automatic issue(input logic [1:0] add, input logic [7:0] na0, input logic [7:0] nb0,
                         input logic [7:0] na1, input logic [7:0] nb1,
                         output logic g, output bit ok);
        bit seen;
        ok = 0;
        g  = 1'b0;
        if (add[0] && !pend[0]) begin a0 = na0; b0 = nb0; end
        if (add[1] && !pend[1]) begin a1 = na1; b1 = nb1; end
        pend = pend | add;
        if (pend == 2'b00) return;
        g = (pend == 2'b11) ? ~m_last : pend[1];
        m_last = g;
        gq.push_back(g);
        rq.push_back(model(g, g ? a1 : a0, g ? b1 : b0));
        req = pend;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (ack != 2'b00) seen = 1;
        end
        check("ack_timeout", {31'b0, !seen}, 0);
        if (!seen) begin
            gq.delete(); rq.delete(); pend = 2'b00; req = 2'b00;
            return;
        end
        pend[g] = 1'b0;
        req = pend;
        ok = 1;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_timeout", {31'b0, !seen}, 0);
        if (!seen) begin
            gq.delete(); rq.delete();
        end
    endtask

    task automatic do_job(input logic [1:0] add, input logic [7:0] na0, input logic [7:0] nb0,
                          input logic [7:0] na1, input logic [7:0] nb1, input bit scr);
        logic g;
        bit ok;
        issue(add, na0, nb0, na1, nb1, g, ok);
        if (!ok) return;
        if (scr) begin
            if (g) begin a1 = rand_op(); b1 = rand_op(); end
            else   begin a0 = rand_op(); b0 = rand_op(); end
        end
        wait_done();
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && pend != 2'b00; i++) do_job(2'b00, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic g;
        bit ok;
        logic [1:0] add;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs", {19'b0, ack, done, done_id, zero, busy, gcd}, 0);

        do_job(2'b01, 8'd12, 8'd8, 8'd0, 8'd0, 0);
        do_job(2'b10, 8'd0, 8'd0, 8'd0, 8'd9, 0);
        do_job(2'b01, 8'd0, 8'd0, 8'd0, 8'd0, 0);
        do_job(2'b01, 8'd255, 8'd1, 8'd0, 8'd0, 0);

        issue(2'b01, 8'd48, 8'd18, 8'd0, 8'd0, g, ok);
        a0 = 8'd5;
        b0 = 8'd5;
        if (ok) wait_done();

        for (int i = 0; i < 4; i++) do_job(2'b11, 8'd36, 8'd24, 8'd35, 8'd14, 0);
        drain();

        for (int i = 0; i < 30; i++) begin
            add = 2'($urandom_range(0, 3));
            if (add == 2'b00 && pend == 2'b00) add = 2'b01;
            do_job(add, rand_op(), rand_op(), rand_op(), rand_op(), 1);
        end
        drain();

        issue(2'b01, 8'd255, 8'd1, 8'd0, 8'd0, g, ok);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {19'b0, ack, done, done_id, zero, busy, gcd}, 0);
        gq.delete();
        rq.delete();
        pend   = 2'b00;
        req    = 2'b00;
        m_last = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_job(2'b11, 8'd36, 8'd24, 8'd35, 8'd14, 0);
        drain();
        do_job(2'b10, 8'd0, 8'd0, 8'd9, 8'd6, 0);

        repeat (20) @(negedge clk);
        check("leftover_expected", 32'(gq.size() + rq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
